// File: rtl/timer_ctrl.sv
// Control FSM for the min:sec countdown timer: turns panel buttons into
// load/clear strobes, paces the seconds count enable and reports status.
module timer_ctrl #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic clearneg,
  input  logic load_btn,
  input  logic start_btn,
  input  logic stop_btn,
  input  logic clr_btn,
  input  logic zero_in,
  output logic loadneg,
  output logic clrneg,
  output logic en,
  output logic running,
  output logic paused,
  output logic done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_READY = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_PAUSE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          load_q, start_q, stop_q, clr_q;
  logic          load_rise, start_rise, stop_rise, clr_rise;

  // History resets high so a button held through reset release never fires.
  always_ff @(posedge clk or negedge clearneg) begin
    if (!clearneg) begin
      load_q  <= 1'b1;
      start_q <= 1'b1;
      stop_q  <= 1'b1;
      clr_q   <= 1'b1;
    end else begin
      load_q  <= load_btn;
      start_q <= start_btn;
      stop_q  <= stop_btn;
      clr_q   <= clr_btn;
    end
  end

  assign load_rise  = load_btn  & ~load_q;
  assign start_rise = start_btn & ~start_q;
  assign stop_rise  = stop_btn  & ~stop_q;
  assign clr_rise   = clr_btn   & ~clr_q;

  always_comb begin
    state_nxt = state;
    if (clr_rise) begin
      state_nxt = S_CLEAR;
    end else if (state == S_CLEAR) begin
      state_nxt = S_IDLE;
    end else if (load_rise) begin
      state_nxt = S_LOAD;
    end else if (state == S_LOAD) begin
      state_nxt = S_READY;
    end else begin
      case (state)
        S_READY: begin
          if (stop_rise)                  state_nxt = S_IDLE;
          else if (start_rise && !zero_in) state_nxt = S_RUN;
        end
        // Reaching zero outranks stop so the alarm is never lost.
        S_RUN: begin
          if (zero_in)        state_nxt = S_DONE;
          else if (stop_rise) state_nxt = S_PAUSE;
        end
        S_PAUSE: begin
          if (stop_rise)       state_nxt = S_IDLE;
          else if (start_rise) state_nxt = S_RUN;
        end
        S_DONE: begin
          if (stop_rise) state_nxt = S_IDLE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    presc_nxt = presc;
    if (state == S_CLEAR)
      presc_nxt = '0;
    else if (state == S_RUN)
      presc_nxt = (presc == LAST) ? '0 : presc + PW'(1);
    else if (state == S_READY && state_nxt == S_RUN)
      presc_nxt = '0;
  end

  always_ff @(posedge clk or negedge clearneg) begin
    if (!clearneg) begin
      state <= S_IDLE;
      presc <= '0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
    end
  end

  // en is gated by zero_in combinationally so the counters cannot underflow.
  assign en      = (state == S_RUN) && (presc == LAST) && !zero_in;
  assign loadneg = (state != S_LOAD);
  assign clrneg  = (state != S_CLEAR);
  assign running = (state == S_RUN);
  assign paused  = (state == S_PAUSE);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a behavioural model.
module tb_timer_ctrl;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic clearneg = 1'b0;
  logic load_btn = 1'b0, start_btn = 1'b0, stop_btn = 1'b0, clr_btn = 1'b0;
  logic zero_in = 1'b0;
  logic loadneg, clrneg, en, running, paused, done;
  logic [5:0] outs;

  always #5 clk = ~clk;

  timer_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .clearneg(clearneg), .load_btn(load_btn), .start_btn(start_btn),
    .stop_btn(stop_btn), .clr_btn(clr_btn), .zero_in(zero_in),
    .loadneg(loadneg), .clrneg(clrneg), .en(en), .running(running),
    .paused(paused), .done(done)
  );

  assign outs = {loadneg, clrneg, en, running, paused, done};

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: mode plus a count of RUN cycles since the timer was armed.
  typedef enum int {M_IDLE, M_LOAD, M_CLEAR, M_READY, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode = M_IDLE;
  mode_t m_next;
  int m_runs = 0;
  logic [3:0] m_prev = 4'hF;
  logic [3:0] m_rise;

  function automatic mode_t next_mode(mode_t m, logic [3:0] r, logic z);
    if (r[3]) return M_CLEAR;
    if (m == M_CLEAR) return M_IDLE;
    if (r[2]) return M_LOAD;
    if (m == M_LOAD) return M_READY;
    case (m)
      M_READY: if (r[1]) return M_IDLE; else if (r[0] && !z) return M_RUN;
      M_RUN:   if (z) return M_DONE; else if (r[1]) return M_PAUSE;
      M_PAUSE: if (r[1]) return M_IDLE; else if (r[0]) return M_RUN;
      M_DONE:  if (r[1]) return M_IDLE;
      default: ;
    endcase
    return m;
  endfunction

  function automatic logic [5:0] exp_outs(mode_t m, int runs, logic z);
    return {m != M_LOAD, m != M_CLEAR,
            (m == M_RUN) && ((runs % TD) == TD - 1) && !z,
            m == M_RUN, m == M_PAUSE, m == M_DONE};
  endfunction

  assign m_rise = {clr_btn, load_btn, stop_btn, start_btn} & ~m_prev;
  assign m_next = next_mode(m_mode, m_rise, zero_in);

  always @(posedge clk or negedge clearneg) begin
    if (!clearneg) begin
      m_mode <= M_IDLE;
      m_runs <= 0;
      m_prev <= 4'hF;
    end else begin
      if (m_mode == M_CLEAR || (m_mode == M_READY && m_next == M_RUN)) m_runs <= 0;
      else if (m_mode == M_RUN) m_runs <= m_runs + 1;
      m_mode <= m_next;
      m_prev <= {clr_btn, load_btn, stop_btn, start_btn};
    end
  end

  always @(negedge clk) chk("model_outs", int'(outs), int'(exp_outs(m_mode, m_runs, zero_in)));

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  int lcount, ccount, en_cnt, run_cnt, k;
  logic [31:0] en_bits;

  initial begin
    // Reset with load and start held across release
    start_btn = 1'b1;
    load_btn  = 1'b1;
    repeat (3) @(posedge clk);
    sample();
    chk("reset_outs", int'(outs), 6'b110000);
    step();
    clearneg = 1'b1;
    lcount = 0;
    run_cnt = 0;
    repeat (4) begin
      step(); sample();
      lcount += int'(!loadneg);
      run_cnt += int'(running);
    end
    chk("held_load_no_strobe", lcount, 0);
    chk("held_start_no_run", run_cnt, 0);
    load_btn = 1'b0;
    start_btn = 1'b0;
    step();

    // Load then run
    load_btn = 1'b1;
    lcount = 0;
    repeat (4) begin
      step(); load_btn = 1'b0; sample();
      lcount += int'(!loadneg);
    end
    chk("load_strobe_len", lcount, 1);
    start_btn = 1'b1;
    en_bits = '0;
    for (int i = 1; i <= 12; i++) begin
      step(); start_btn = 1'b0; sample();
      en_bits[i] = en;
      if (i == 1) chk("running_after_start", int'(running), 1);
    end
    chk("en_pattern", int'(en_bits), 32'h1110);

    // Counters reach zero after the third pulse
    step(); zero_in = 1'b1; sample();
    en_cnt = int'(en);
    chk("still_running_at_zero", int'(running), 1);
    step(); sample();
    chk("done_after_zero", int'(done), 1);
    chk("running_cleared", int'(running), 0);
    repeat (6) begin step(); sample(); en_cnt += int'(en); end
    chk("no_en_after_zero", en_cnt, 0);
    chk("done_held", int'(done), 1);
    stop_btn = 1'b1;
    step(); stop_btn = 1'b0; sample();
    chk("stop_clears_done", int'(done), 0);
    step(); zero_in = 1'b0;

    // Pause at RUN cycle 2, resume
    load_btn = 1'b1; step(); load_btn = 1'b0; step();
    start_btn = 1'b1; step(); start_btn = 1'b0; sample();
    en_cnt = int'(en);
    step(); stop_btn = 1'b1; sample();
    en_cnt += int'(en);
    step(); stop_btn = 1'b0; sample();
    chk("paused", int'(paused), 1);
    repeat (20) begin step(); sample(); en_cnt += int'(en); end
    chk("no_en_paused", en_cnt, 0);
    start_btn = 1'b1;
    en_bits = '0;
    for (int i = 1; i <= 3; i++) begin
      step(); start_btn = 1'b0; sample();
      en_bits[i] = en;
    end
    chk("resume_en", int'(en_bits), 32'h4);

    // clr, load and start rise together during RUN
    clr_btn = 1'b1; load_btn = 1'b1; start_btn = 1'b1;
    ccount = 0;
    lcount = 0;
    repeat (4) begin
      step(); clr_btn = 1'b0; load_btn = 1'b0; start_btn = 1'b0; sample();
      ccount += int'(!clrneg);
      lcount += int'(!loadneg);
    end
    chk("prio_clr_strobe", ccount, 1);
    chk("prio_no_load", lcount, 0);
    chk("prio_idle_status", int'({running, paused, done}), 0);
    start_btn = 1'b1; step(); start_btn = 1'b0; step(); sample();
    chk("idle_ignores_start", int'(running), 0);

    // Start with zero_in high in READY
    load_btn = 1'b1; step(); load_btn = 1'b0; zero_in = 1'b1; step();
    start_btn = 1'b1;
    en_cnt = 0;
    run_cnt = 0;
    repeat (6) begin
      step(); start_btn = 1'b0; sample();
      en_cnt += int'(en);
      run_cnt += int'(running);
    end
    chk("zero_start_no_run", run_cnt, 0);
    chk("zero_start_no_en", en_cnt, 0);
    step(); zero_in = 1'b0; start_btn = 1'b1;
    step(); start_btn = 1'b0; sample();
    chk("ready_kept", int'(running), 1);

    // Asynchronous reset in the middle of an en cycle
    k = 0;
    while (en !== 1'b1 && k < 10) begin sample(); k++; end
    chk("en_seen_before_reset", int'(en), 1);
    #1 clearneg = 1'b0;
    #1;
    chk("async_running", int'(running), 0);
    chk("async_en", int'(en), 0);
    chk("async_outs", int'(outs), 6'b110000);
    step(); step();
    clearneg = 1'b1;

    // Randomized traffic
    repeat (3000) begin
      step();
      clr_btn   = ($urandom_range(0, 39) == 0);
      load_btn  = ($urandom_range(0, 14) == 0);
      stop_btn  = ($urandom_range(0, 11) == 0);
      start_btn = ($urandom_range(0, 3) == 0);
      zero_in   = ($urandom_range(0, 29) == 0);
      clearneg  = ($urandom_range(0, 499) != 0);
    end
    clearneg = 1'b1;
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Control FSM for the min:sec countdown timer. It drives the cascaded mod-10/mod-6 digit counters through their `loadneg`, `en` and clear inputs, and consumes their combined `zero` flag. It turns the front-panel buttons (load, start, stop, clear) into single-cycle load/clear strobes and a one-cycle-per-second count enable. It also reports running/paused/done status to the display and alarm logic.

## Interface
- `TICK_DIV`, default 100: clock cycles per count-enable pulse (one second at the system clock); legal values are 2 or more.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clearneg`  in  1  reset, asynchronous and active-low.
- `load_btn`  in  1  load request, level input, synchronous to `clk`.
- `start_btn`  in  1  start/resume request, level input.
- `stop_btn`  in  1  pause/abort request, level input.
- `clr_btn`  in  1  clear request, level input.
- `zero_in`  in  1  high when every digit counter reports zero (AND of the counters' `zero` outputs).
- `loadneg`  out  1  active-low parallel-load strobe to all digit counters.
- `clrneg`  out  1  active-low clear strobe to all digit counters.
- `en`  out  1  count enable to the least-significant seconds counter.
- `running`  out  1  high in RUN.
- `paused`  out  1  high in PAUSE.
- `done`  out  1  high in DONE (alarm request).

## Operation
- Button edge detection:
  - Each button has a history register; a "rise" is `btn & ~btn_q`.
  - History registers reset to 1, so a button held through reset release does not fire.
- States:
  - IDLE: reset state.
  - LOAD: transient, one cycle.
  - CLEAR: transient, one cycle.
  - READY, RUN, PAUSE, DONE.
- Priority when several rises occur in the same cycle: clr > load > stop > start. Only the highest-priority rise acts; the others are discarded.
- From any state:
  - clr rise goes to CLEAR.
  - CLEAR always goes to IDLE.
  - Otherwise, load rise goes to LOAD. LOAD always goes to READY.
- READY:
  - start rise with `zero_in`=0 goes to RUN and sets the prescaler to 0.
  - start rise with `zero_in`=1 is ignored; the state stays READY.
  - stop rise goes to IDLE.
- RUN:
  - `zero_in`=1 goes to DONE. This takes precedence over stop/start but not over clr/load.
  - Otherwise, stop rise goes to PAUSE and the prescaler holds its value.
- PAUSE:
  - start rise goes to RUN, with the prescaler resuming from its held value.
  - stop rise goes to IDLE.
- DONE:
  - Held until a clr, load or stop rise; stop goes to IDLE.
  - start is ignored.
- IDLE: start and stop are ignored.
- Prescaler:
  - `$clog2(TICK_DIV)` bits wide.
  - Increments every RUN cycle and wraps from TICK_DIV-1 to 0.
  - Frozen outside RUN.
  - Cleared on entry to RUN from READY and in CLEAR.
- Outputs:
  - `loadneg` = 0 only in LOAD.
  - `clrneg` = 0 only in CLEAR.
  - `running`, `paused`, `done` are decoded from the state register.
  - `en` = (state==RUN) & (prescaler==TICK_DIV-1) & ~`zero_in`. This is combinational on `zero_in`, so the counters can never be decremented past zero.

## Timing
- Reset values:
  - state IDLE, prescaler 0, button history regs 1.
  - `loadneg`=1, `clrneg`=1, `en`=0, `running`=0, `paused`=0, `done`=0.
- Assertion of `clearneg` mid-operation (including mid-LOAD or mid-RUN) forces the reset values immediately, without waiting for a clock edge.
- Button latency: a rise sampled at edge k changes the state at edge k. The strobe or status is visible in the cycle after edge k.
- `loadneg` and `clrneg` are low for exactly one clock cycle per accepted request.
- Tick timing:
  - From READY, the first `en` pulse occurs in the TICK_DIV-th cycle of RUN.
  - Later pulses follow every TICK_DIV cycles, each one cycle wide.
- Pause/resume: after PAUSE then RUN, the pulse spacing counts only RUN cycles. Total RUN cycles between pulses is always TICK_DIV.
- Zero detection: `zero_in` rising in RUN (the cycle after the final `en`) gives DONE one edge later. No further `en` is issued.
- Buttons are pre-synchronised upstream; this block does not debounce.

## Test plan
- Reset:
  - Hold `start_btn`=1 across `clearneg` release -> no RUN.
  - All outputs at reset values.
  - Then `clearneg` low mid-RUN -> `running`=0 and `en`=0 without waiting for a clock edge.
- Load then run, TICK_DIV=4:
  - load pulse -> `loadneg` low exactly 1 cycle, state READY.
  - start -> `en` high on RUN cycles 4, 8, 12, … each 1 cycle wide.
- Countdown end, TICK_DIV=4:
  - Drive `zero_in`=1 the cycle after the 3rd `en` -> no 4th `en`.
  - `done`=1 from the next cycle.
  - stop -> IDLE, `done`=0.
- Pause/resume, TICK_DIV=4:
  - stop at RUN cycle 2 -> `paused`=1, `en` stays 0 for 20 cycles.
  - start -> next `en` 2 RUN cycles later.
- Priority: clr, load and start rising in the same cycle during RUN -> `clrneg` low 1 cycle, no `loadneg` strobe, then IDLE.
- Start with `zero_in`=1 in READY -> stays READY, `en` never asserted.
